// File: rtl/multilevel_cache_ctrl_pkg.sv
// rtl/multilevel_cache_ctrl_pkg.sv - shared opcodes, level codes, FSM states and helpers
package multilevel_cache_ctrl_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_INVAL = 2'b11;

    localparam logic [1:0] LVL_MISS = 2'b00;
    localparam logic [1:0] LVL_L1   = 2'b01;
    localparam logic [1:0] LVL_L2   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L1_LK,
        ST_L2_LK,
        ST_SWAP,
        ST_ALLOC,
        ST_RESP
    } state_t;

    // Index width for an array of n lines; a single-line level still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multilevel_cache_ctrl_level.sv
// rtl/multilevel_cache_ctrl_level.sv - one fully associative cache level with match, victim select and write port
module cache_level
    import multilevel_cache_ctrl_pkg::*;
#(
    parameter int ENTRIES = 2,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 4,
    localparam int IDX_W  = idx_w(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              hit,
    output logic [IDX_W-1:0]  hit_idx,
    output logic [DATA_W-1:0] hit_data,
    output logic [IDX_W-1:0]  victim_idx,
    output logic              victim_valid,
    output logic [TAG_W-1:0]  victim_tag,
    output logic [DATA_W-1:0] victim_data,
    input  logic              we,
    input  logic [IDX_W-1:0]  w_idx,
    input  logic [TAG_W-1:0]  w_tag,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_valid,
    input  logic              rr_adv
);

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags     [ENTRIES];
    logic [DATA_W-1:0]  data_arr [ENTRIES];
    logic [IDX_W-1:0]   rr;
    logic               free_found;

    // Tag match; exclusivity guarantees at most one line matches.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid[i] && tags[i] == lookup_tag && !hit) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Victim: lowest-index free line, else the round-robin line.
    always_comb begin
        free_found = 1'b0;
        victim_idx = rr;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!valid[i] && !free_found) begin
                free_found = 1'b1;
                victim_idx = IDX_W'(i);
            end
        end
    end

    assign hit_data     = data_arr[hit_idx];
    assign victim_valid = valid[victim_idx];
    assign victim_tag   = tags[victim_idx];
    assign victim_data  = data_arr[victim_idx];

    // Valid bits and rr pointer; reset invalidates the whole level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            rr    <= '0;
        end else begin
            if (we)
                valid[w_idx] <= w_valid;
            if (rr_adv)
                rr <= (rr == IDX_W'(ENTRIES - 1)) ? '0 : rr + 1'b1;
        end
    end

    // Tag/data storage needs no reset since valid bits gate every use.
    always_ff @(posedge clk) begin
        if (we) begin
            tags[w_idx]     <= w_tag;
            data_arr[w_idx] <= w_data;
        end
    end

endmodule

// File: rtl/multilevel_cache_ctrl.sv
// rtl/multilevel_cache_ctrl.sv - two-level exclusive cache controller with request handshake and L2 eviction port
module multilevel_cache_ctrl
    import multilevel_cache_ctrl_pkg::*;
#(
    parameter int TAG_W      = 4,
    parameter int DATA_W     = 4,
    parameter int OPCODE_W   = 2,
    parameter int L1_ENTRIES = 2,
    parameter int L2_ENTRIES = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [OPCODE_W+TAG_W+DATA_W-1:0] req_vector,
    output logic                             resp_valid,
    output logic [DATA_W-1:0]                resp_data,
    output logic [1:0]                       resp_level,
    output logic                             evict_valid,
    output logic [TAG_W-1:0]                 evict_tag,
    output logic [DATA_W-1:0]                evict_data
);

    localparam int I1 = idx_w(L1_ENTRIES);
    localparam int I2 = idx_w(L2_ENTRIES);

    state_t state, next;
    logic [OPCODE_W-1:0] op_q;
    logic [TAG_W-1:0]    tag_q, etag_q;
    logic [DATA_W-1:0]   data_q, rdata_q, edata_q;
    logic [1:0]          level_q;
    logic                evict_q;

    logic              l1_hit, l1_vvalid, l1_we, l1_wvalid, l1_adv;
    logic [I1-1:0]     l1_hidx, l1_vidx, l1_widx;
    logic [DATA_W-1:0] l1_hdata, l1_vdata, l1_wdata;
    logic [TAG_W-1:0]  l1_vtag, l1_wtag;
    logic              l2_hit, l2_vvalid, l2_we, l2_wvalid, l2_adv;
    logic [I2-1:0]     l2_hidx, l2_vidx, l2_widx;
    logic [DATA_W-1:0] l2_hdata, l2_vdata, l2_wdata;
    logic [TAG_W-1:0]  l2_vtag, l2_wtag;

    cache_level #(.ENTRIES(L1_ENTRIES), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_l1 (
        .clk(clk), .rst(rst), .lookup_tag(tag_q),
        .hit(l1_hit), .hit_idx(l1_hidx), .hit_data(l1_hdata),
        .victim_idx(l1_vidx), .victim_valid(l1_vvalid), .victim_tag(l1_vtag), .victim_data(l1_vdata),
        .we(l1_we), .w_idx(l1_widx), .w_tag(l1_wtag), .w_data(l1_wdata), .w_valid(l1_wvalid),
        .rr_adv(l1_adv)
    );

    cache_level #(.ENTRIES(L2_ENTRIES), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_l2 (
        .clk(clk), .rst(rst), .lookup_tag(tag_q),
        .hit(l2_hit), .hit_idx(l2_hidx), .hit_data(l2_hdata),
        .victim_idx(l2_vidx), .victim_valid(l2_vvalid), .victim_tag(l2_vtag), .victim_data(l2_vdata),
        .we(l2_we), .w_idx(l2_widx), .w_tag(l2_wtag), .w_data(l2_wdata), .w_valid(l2_wvalid),
        .rr_adv(l2_adv)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next;
    end

    // Next state and array write controls; all line moves land on the SWAP/ALLOC edge.
    always_comb begin
        next      = state;
        l1_we     = 1'b0;
        l1_widx   = l1_vidx;
        l1_wtag   = tag_q;
        l1_wdata  = data_q;
        l1_wvalid = 1'b1;
        l1_adv    = 1'b0;
        l2_we     = 1'b0;
        l2_widx   = l2_vidx;
        l2_wtag   = l1_vtag;
        l2_wdata  = l1_vdata;
        l2_wvalid = l1_vvalid;
        l2_adv    = 1'b0;
        case (state)
            ST_IDLE: if (req_valid) next = ST_L1_LK;
            ST_L1_LK: begin
                if (op_q == OP_NOP) begin
                    next = ST_RESP;
                end else if (l1_hit) begin
                    next      = ST_RESP;
                    l1_widx   = l1_hidx;
                    l1_we     = (op_q == OP_WRITE) || (op_q == OP_INVAL);
                    l1_wvalid = (op_q == OP_WRITE);
                end else begin
                    next = ST_L2_LK;
                end
            end
            ST_L2_LK: next = l2_hit ? ST_SWAP : ST_ALLOC;
            ST_SWAP: begin
                next    = ST_RESP;
                l2_we   = 1'b1;
                l2_widx = l2_hidx;
                if (op_q == OP_INVAL) begin
                    l2_wvalid = 1'b0;
                end else begin
                    // The freed L2 slot takes the L1 victim, so L2 never evicts here.
                    l1_we    = 1'b1;
                    l1_wdata = (op_q == OP_READ) ? l2_hdata : data_q;
                    l1_adv   = l1_vvalid;
                end
            end
            ST_ALLOC: begin
                next = ST_RESP;
                if (op_q == OP_WRITE) begin
                    l1_we  = 1'b1;
                    l1_adv = l1_vvalid;
                    l2_we  = l1_vvalid;
                    l2_adv = l1_vvalid && l2_vvalid;
                end
            end
            ST_RESP: next = ST_IDLE;
            default: next = ST_IDLE;
        endcase
    end

    // Request capture and response/eviction holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            level_q <= LVL_MISS;
            evict_q <= 1'b0;
            etag_q  <= '0;
            edata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    op_q    <= req_vector[OPCODE_W+TAG_W+DATA_W-1 -: OPCODE_W];
                    tag_q   <= req_vector[TAG_W+DATA_W-1 -: TAG_W];
                    data_q  <= req_vector[DATA_W-1:0];
                    rdata_q <= '0;
                    level_q <= LVL_MISS;
                    evict_q <= 1'b0;
                end
                ST_L1_LK: if (op_q != OP_NOP && l1_hit) begin
                    level_q <= LVL_L1;
                    if (op_q == OP_READ) rdata_q <= l1_hdata;
                end
                ST_SWAP: begin
                    level_q <= LVL_L2;
                    if (op_q == OP_READ) rdata_q <= l2_hdata;
                end
                ST_ALLOC: if (op_q == OP_WRITE && l1_vvalid && l2_vvalid) begin
                    evict_q <= 1'b1;
                    etag_q  <= l2_vtag;
                    edata_q <= l2_vdata;
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = (state == ST_IDLE);
    assign resp_valid  = (state == ST_RESP);
    assign resp_data   = resp_valid ? rdata_q : '0;
    assign resp_level  = resp_valid ? level_q : LVL_MISS;
    assign evict_valid = resp_valid && evict_q;
    assign evict_tag   = evict_valid ? etag_q : '0;
    assign evict_data  = evict_valid ? edata_q : '0;

endmodule

// File: tb/tb_multilevel_cache_ctrl.sv
// tb/tb_multilevel_cache_ctrl.sv - directed self-checking bench for multilevel_cache_ctrl
module tb_multilevel_cache_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a_valid = 1'b0, a_ready, a_resp_valid, a_evict_valid;
    logic [9:0] a_vec = '0;
    logic [3:0] a_resp_data, a_evict_tag, a_evict_data;
    logic [1:0] a_resp_level;

    logic        b_valid = 1'b0, b_ready, b_resp_valid, b_evict_valid;
    logic [10:0] b_vec = '0;
    logic [3:0]  b_resp_data, b_evict_data;
    logic [4:0]  b_evict_tag;
    logic [1:0]  b_resp_level;

    int n_checks = 0;
    int n_errors = 0;
    int r_lat, r_level, r_data, r_evicts, r_etag, r_edata, r_busy, r_post_ready, r_post_resp;

    always #5 clk = ~clk;

    multilevel_cache_ctrl dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_vector(a_vec),
        .resp_valid(a_resp_valid), .resp_data(a_resp_data), .resp_level(a_resp_level),
        .evict_valid(a_evict_valid), .evict_tag(a_evict_tag), .evict_data(a_evict_data)
    );

    multilevel_cache_ctrl #(.TAG_W(5)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_vector(b_vec),
        .resp_valid(b_resp_valid), .resp_data(b_resp_data), .resp_level(b_resp_level),
        .evict_valid(b_evict_valid), .evict_tag(b_evict_tag), .evict_data(b_evict_data)
    );

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_ready"}, a_ready, 1);
        check({name, "_rvalid"}, a_resp_valid, 0);
        check({name, "_rdata"}, a_resp_data, 0);
        check({name, "_rlevel"}, a_resp_level, 0);
        check({name, "_evalid"}, a_evict_valid, 0);
        check({name, "_b_ready"}, b_ready, 1);
    endtask

    // One request: present at a negedge, accepted on the next posedge, then watch negedges.
    task automatic send(input bit big, input logic [1:0] op, input logic [4:0] tag, input logic [3:0] data);
        int lat;
        bit seen;
        @(negedge clk);
        if (big) begin b_valid = 1'b1; b_vec = {op, tag, data}; end
        else     begin a_valid = 1'b1; a_vec = {op, tag[3:0], data}; end
        @(posedge clk);
        #1;
        a_valid = 1'b0; b_valid = 1'b0;
        r_busy = big ? b_ready : a_ready;
        lat = 0; seen = 1'b0;
        r_level = 0; r_data = 0; r_evicts = 0; r_etag = 0; r_edata = 0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            if (big ? b_evict_valid : a_evict_valid) begin
                r_evicts++;
                r_etag  = big ? b_evict_tag : a_evict_tag;
                r_edata = big ? b_evict_data : a_evict_data;
            end
            if (big ? b_resp_valid : a_resp_valid) begin
                seen    = 1'b1;
                r_level = big ? b_resp_level : a_resp_level;
                r_data  = big ? b_resp_data : a_resp_data;
            end
        end
        r_lat = seen ? lat : 99;
        @(negedge clk);
        r_post_ready = big ? b_ready : a_ready;
        r_post_resp  = big ? b_resp_valid : a_resp_valid;
        if (big ? b_evict_valid : a_evict_valid) r_evicts++;
    endtask

    task automatic xact(input bit big, input string name, input logic [1:0] op, input logic [4:0] tag,
                        input logic [3:0] data, input int exp_lvl, input int exp_data, input int exp_lat,
                        input int exp_ev);
        send(big, op, tag, data);
        check({name, "_lat"}, r_lat, exp_lat);
        check({name, "_lvl"}, r_level, exp_lvl);
        check({name, "_data"}, r_data, exp_data);
        check({name, "_busy"}, r_busy, 0);
        check({name, "_post_ready"}, r_post_ready, 1);
        check({name, "_post_resp"}, r_post_resp, 0);
        check({name, "_evicts"}, r_evicts, exp_ev);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int held_data;
        int ev_sum;

        // T1: reset state, then a cold READ misses with 4-cycle latency
        do_reset();
        check_quiet("rst");
        xact(0, "t1_rd3", 2'b01, 5'd3, 4'h0, 0, 0, 4, 0);

        // T2: WRITE miss allocates in L1, READ hits L1 in 2 cycles; NOP responds with level 00
        xact(0, "t2_wr3", 2'b10, 5'd3, 4'hA, 0, 0, 4, 0);
        xact(0, "t2_rd3", 2'b01, 5'd3, 4'h0, 1, 10, 2, 0);
        xact(0, "t2_nop", 2'b00, 5'd3, 4'h0, 0, 0, 2, 0);

        // T3: third write pushes tag 1 to L2; READ 1 swaps it back, tag 2 goes to L2
        do_reset();
        xact(0, "t3_wr1", 2'b10, 5'd1, 4'h1, 0, 0, 4, 0);
        xact(0, "t3_wr2", 2'b10, 5'd2, 4'h2, 0, 0, 4, 0);
        xact(0, "t3_wr3", 2'b10, 5'd3, 4'h3, 0, 0, 4, 0);
        xact(0, "t3_rd1", 2'b01, 5'd1, 4'h0, 2, 1, 4, 0);
        xact(0, "t3_rd1b", 2'b01, 5'd1, 4'h0, 1, 1, 2, 0);
        xact(0, "t3_rd2", 2'b01, 5'd2, 4'h0, 2, 2, 4, 0);

        // T5: L1 = {2,1}, L2 = {3}; invalidate the L2-resident tag
        xact(0, "t5_inv3", 2'b11, 5'd3, 4'h0, 2, 0, 4, 0);
        xact(0, "t5_rd3", 2'b01, 5'd3, 4'h0, 0, 0, 4, 0);
        xact(0, "t5_inv9", 2'b11, 5'd9, 4'h0, 0, 0, 4, 0);

        // T5: req_valid held through a busy L1 hit with a changed vector gives one response
        @(negedge clk);
        a_valid = 1'b1; a_vec = {2'b01, 4'd2, 4'h0};
        @(posedge clk);
        #1;
        a_vec = {2'b10, 4'd2, 4'hF};
        pulses = 0; held_data = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_resp_valid) begin
                pulses++;
                held_data = a_resp_data;
                a_valid = 1'b0;
            end
        end
        a_valid = 1'b0;
        check("t5_held_pulses", pulses, 1);
        check("t5_held_data", held_data, 2);
        xact(0, "t5_rd2", 2'b01, 5'd2, 4'h0, 1, 2, 2, 0);
        xact(0, "t5_inv1", 2'b11, 5'd1, 4'h0, 1, 0, 2, 0);
        xact(0, "t5_rd1", 2'b01, 5'd1, 4'h0, 0, 0, 4, 0);

        // T4: TAG_W=5; 18 writes fill both levels, the 19th evicts tag 0
        do_reset();
        ev_sum = 0;
        for (int t = 0; t < 18; t++) begin
            send(1, 2'b10, 5'(t), 4'(t));
            ev_sum += r_evicts;
        end
        check("t4_fill_evicts", ev_sum, 0);
        xact(1, "t4_wr18", 2'b10, 5'd18, 4'h2, 0, 0, 4, 1);
        check("t4_etag", r_etag, 0);
        check("t4_edata", r_edata, 0);
        xact(1, "t4_rd17", 2'b01, 5'd17, 4'h0, 1, 1, 2, 0);
        xact(1, "t4_rd5", 2'b01, 5'd5, 4'h0, 2, 5, 4, 0);
        xact(1, "t4_rd0", 2'b01, 5'd0, 4'h0, 0, 0, 4, 0);

        // T6: reset asserted during the SWAP cycle of READ 1 leaves everything invalid
        do_reset();
        xact(0, "t6_wr1", 2'b10, 5'd1, 4'h1, 0, 0, 4, 0);
        xact(0, "t6_wr2", 2'b10, 5'd2, 4'h2, 0, 0, 4, 0);
        xact(0, "t6_wr3", 2'b10, 5'd3, 4'h3, 0, 0, 4, 0);
        @(negedge clk);
        a_valid = 1'b1; a_vec = {2'b01, 4'd1, 4'h0};
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_quiet("t6_post");
        xact(0, "t6_rd1", 2'b01, 5'd1, 4'h0, 0, 0, 4, 0);
        xact(0, "t6_rd2", 2'b01, 5'd2, 4'h0, 0, 0, 4, 0);
        xact(0, "t6_rd3", 2'b01, 5'd3, 4'h0, 0, 0, 4, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
